// File: rtl/monitor_output_recorder_if.sv
// Record stream carrying one header word, then one word per active output.
// The master drives the words and the slave answers with rec_ready.
interface monitor_output_recorder_if #(
  parameter int DATA_W = 64
);
  logic              rec_valid;
  logic              rec_ready;
  logic              rec_hdr;
  logic [7:0]        rec_idx;
  logic              rec_last;
  logic [DATA_W-1:0] rec_word;

  modport master (
    output rec_valid, rec_hdr, rec_idx, rec_last, rec_word,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_hdr, rec_idx, rec_last, rec_word,
    output rec_ready
  );
endinterface

// File: rtl/monitor_output_recorder.sv
// Timestamps each cycle that has active monitor outputs and queues the record in a FIFO.
// It then sends each record as a header word followed by one word per active output.
module monitor_output_recorder #(
  parameter int NUM_OUT = 14,
  parameter int DATA_W  = 64,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic signed [NUM_OUT*DATA_W-1:0]  out_data,
  input  logic        [NUM_OUT-1:0]         out_aktv,
  monitor_output_recorder_if.master         rec,
  output logic                              ovf,
  output logic        [15:0]                drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  function automatic logic [7:0] lowest_from(input logic [NUM_OUT-1:0] m, input int start);
    logic [7:0] r;
    r = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--)
      if (m[i] && (i >= start)) r = 8'(i);
    return r;
  endfunction

  function automatic logic [7:0] highest(input logic [NUM_OUT-1:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (m[i]) r = 8'(i);
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Record storage carries no reset; the pointers and the count alone decide what is valid
  logic [TS_W-1:0]           ts_mem   [DEPTH];
  logic [NUM_OUT-1:0]        mask_mem [DEPTH];
  logic [NUM_OUT*DATA_W-1:0] data_mem [DEPTH];

  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  state_t          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;

  logic                      capture, full, push, pop, drop, last;
  logic [TS_W-1:0]           head_ts;
  logic [NUM_OUT-1:0]        head_mask;
  logic [NUM_OUT*DATA_W-1:0] head_data;
  logic [DATA_W-1:0]         head_val;
  logic [DATA_W-1:0]         hdr_word;

  // The head entry keeps its slot until its last word is accepted, so a stalled record cannot be overwritten
  assign head_ts   = ts_mem[rd_ptr_q];
  assign head_mask = mask_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  assign capture = en && (|out_aktv);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push    = capture && !full;
  assign drop    = capture && full;
  assign last    = (state_q == DATA) && (idx_q == highest(head_mask));

  always_comb begin
    head_val = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (idx_q == 8'(i)) head_val = head_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    hdr_word                  = '0;
    hdr_word[TS_W-1:0]        = head_ts;
    hdr_word[TS_W +: NUM_OUT] = head_mask;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (count_q != '0) state_d = HDR;
      HDR: begin
        if (rec.rec_ready) begin
          state_d = DATA;
          idx_d   = lowest_from(head_mask, 0);
        end
      end
      DATA: begin
        if (rec.rec_ready) begin
          if (last) begin
            pop     = 1'b1;
            idx_d   = '0;
            state_d = ((count_q > (AW+1)'(1)) || push) ? HDR : IDLE;
          end else begin
            idx_d = lowest_from(head_mask, int'(idx_q) + 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_d     = en   ? ts_q + TS_W'(1)   : ts_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d  = ovf_q | drop;
    drop_d = drop ? sat_inc16(drop_q) : drop_q;
  end

  always_comb begin
    rec.rec_valid = (state_q != IDLE);
    rec.rec_hdr   = (state_q == HDR);
    rec.rec_idx   = (state_q == DATA) ? idx_q : 8'd0;
    rec.rec_last  = last;
    rec.rec_word  = '0;
    if (state_q == HDR)  rec.rec_word = hdr_word;
    if (state_q == DATA) rec.rec_word = head_val;
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_ptr_q]   <= ts_q;
      mask_mem[wr_ptr_q] <= out_aktv;
      data_mem[wr_ptr_q] <= out_data;
    end
  end

endmodule

// File: tb/tb_monitor_output_recorder.sv
// Directed bench for monitor_output_recorder: a 32-bit timestamp instance plus an 8-bit one for the wrap case.
module tb_monitor_output_recorder;
  localparam int NUM_OUT = 14;
  localparam int DATA_W  = 64;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      en  = 1'b0;
  logic                      en8 = 1'b0;
  logic [NUM_OUT*DATA_W-1:0] out_data = '0;
  logic [NUM_OUT-1:0]        out_aktv = '0;
  logic                      ovf, ovf8;
  logic [15:0]               drop_cnt, drop_cnt8;

  int          checks = 0;
  int          errors = 0;
  int unsigned tsm    = 0;
  logic [7:0]  tsm8   = '0;

  always #5 clk = ~clk;

  monitor_output_recorder_if #(.DATA_W(DATA_W)) rif ();
  monitor_output_recorder_if #(.DATA_W(DATA_W)) rif8 ();

  monitor_output_recorder #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .TS_W(32), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .rec(rif.master), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  monitor_output_recorder #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .TS_W(8), .DEPTH(16)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .out_data(out_data), .out_aktv(out_aktv),
    .rec(rif8.master), .ovf(ovf8), .drop_cnt(drop_cnt8)
  );

  // Observed word bundle: {valid, hdr, idx, last, word}
  wire [74:0] obs  = {rif.rec_valid, rif.rec_hdr, rif.rec_idx, rif.rec_last, rif.rec_word};
  wire [74:0] obs8 = {rif8.rec_valid, rif8.rec_hdr, rif8.rec_idx, rif8.rec_last, rif8.rec_word};

  function automatic logic [74:0] hdr_exp(input logic [31:0] ts, input logic [13:0] m);
    logic [63:0] w;
    w = '0;
    w[31:0]  = ts;
    w[45:32] = m;
    return {1'b1, 1'b1, 8'd0, 1'b0, w};
  endfunction

  function automatic logic [74:0] hdr8_exp(input logic [7:0] ts, input logic [13:0] m);
    logic [63:0] w;
    w = '0;
    w[7:0]  = ts;
    w[21:8] = m;
    return {1'b1, 1'b1, 8'd0, 1'b0, w};
  endfunction

  function automatic logic [74:0] dat_exp(input logic [7:0] idx, input logic [63:0] v, input logic lst);
    return {1'b1, 1'b0, idx, lst, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      tsm  = 0;
      tsm8 = '0;
    end else begin
      if (en)  tsm++;
      if (en8) tsm8++;
    end
    #1;
  endtask

  task automatic set_out(input int i, input logic [63:0] v);
    out_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic test_reset();
    rif.rec_ready  = 1'b1;
    rif8.rec_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
    checks++;
    if ({ovf, drop_cnt} !== 17'd0) begin errors++; $display("FAIL reset_ovf_drop got %h want 0", {ovf, drop_cnt}); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] t0;
    en = 1'b1;
    repeat (500) tick();
    set_out(0, 64'd7);
    out_aktv = 14'h0001;
    t0 = tsm;
    tick();
    out_aktv = '0;
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL single_latency got %h want 0", obs); end
    tick();
    checks++;
    if (obs !== hdr_exp(32'd500, 14'h0001)) begin errors++; $display("FAIL single_hdr got %h want %h", obs, hdr_exp(32'd500, 14'h0001)); end
    tick();
    checks++;
    if (obs !== dat_exp(8'd0, 64'd7, 1'b1)) begin errors++; $display("FAIL single_data got %h want %h", obs, dat_exp(8'd0, 64'd7, 1'b1)); end
    tick();
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL single_idle got %h want 0 (ts %0d)", obs, t0); end
  endtask

  task automatic test_multi();
    logic [31:0] t0;
    set_out(2, 64'hFFFF_FFFF_FFFF_FFFD);
    set_out(5, 64'd9);
    set_out(13, 64'd42);
    out_aktv = 14'h2024;
    t0 = tsm;
    tick();
    out_aktv = '0;
    tick();
    checks++;
    if (obs !== hdr_exp(t0, 14'h2024)) begin errors++; $display("FAIL multi_hdr got %h want %h", obs, hdr_exp(t0, 14'h2024)); end
    tick();
    checks++;
    if (obs !== dat_exp(8'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0)) begin errors++; $display("FAIL multi_idx2 got %h", obs); end
    tick();
    checks++;
    if (obs !== dat_exp(8'd5, 64'd9, 1'b0)) begin errors++; $display("FAIL multi_idx5 got %h", obs); end
    tick();
    checks++;
    if (obs !== dat_exp(8'd13, 64'd42, 1'b1)) begin errors++; $display("FAIL multi_idx13 got %h", obs); end
    tick();
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL multi_idle got %h want 0", obs); end
  endtask

  task automatic test_stall();
    logic [31:0] t0;
    set_out(0, 64'd10);
    set_out(1, 64'd11);
    set_out(2, 64'd12);
    out_aktv = 14'h0007;
    t0 = tsm;
    tick();
    out_aktv = '0;
    tick();
    checks++;
    if (obs !== hdr_exp(t0, 14'h0007)) begin errors++; $display("FAIL stall_hdr got %h", obs); end
    tick();
    checks++;
    if (obs !== dat_exp(8'd0, 64'd10, 1'b0)) begin errors++; $display("FAIL stall_idx0 got %h", obs); end
    tick();
    checks++;
    if (obs !== dat_exp(8'd1, 64'd11, 1'b0)) begin errors++; $display("FAIL stall_idx1 got %h", obs); end
    rif.rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== dat_exp(8'd1, 64'd11, 1'b0)) begin errors++; $display("FAIL stall_hold cycle %0d got %h", i, obs); end
    end
    rif.rec_ready = 1'b1;
    tick();
    checks++;
    if (obs !== dat_exp(8'd2, 64'd12, 1'b1)) begin errors++; $display("FAIL stall_idx2 got %h", obs); end
    tick();
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL stall_idle got %h want 0", obs); end
  endtask

  task automatic test_overflow();
    logic [31:0] tsq [20];
    rif.rec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_out(3, 64'(i + 100));
      out_aktv = 14'h0008;
      tsq[i] = tsm;
      tick();
    end
    out_aktv = '0;
    checks++;
    if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 4", drop_cnt); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf); end
    rif.rec_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (obs !== hdr_exp(tsq[r], 14'h0008)) begin errors++; $display("FAIL ovf_hdr rec %0d got %h want %h", r, obs, hdr_exp(tsq[r], 14'h0008)); end
      tick();
      checks++;
      if (obs !== dat_exp(8'd3, 64'(r + 100), 1'b1)) begin errors++; $display("FAIL ovf_data rec %0d got %h", r, obs); end
      tick();
    end
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL ovf_drained got %h want 0", obs); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] t0;
    rif.rec_ready = 1'b0;
    set_out(1, 64'd21);
    set_out(4, 64'd24);
    out_aktv = 14'h0012;
    tick();
    set_out(0, 64'd30);
    out_aktv = 14'h0001;
    tick();
    set_out(6, 64'd40);
    out_aktv = 14'h0040;
    tick();
    out_aktv = '0;
    rif.rec_ready = 1'b1;
    tick();
    checks++;
    if (obs !== dat_exp(8'd1, 64'd21, 1'b0)) begin errors++; $display("FAIL rmid_pre got %h", obs); end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL rmid_async got %h want 0", obs); end
    checks++;
    if ({ovf, drop_cnt} !== 17'd0) begin errors++; $display("FAIL rmid_ovf_drop got %h want 0", {ovf, drop_cnt}); end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== 75'd0) begin errors++; $display("FAIL rmid_stale cycle %0d got %h want 0", i, obs); end
    end
    set_out(7, 64'd99);
    out_aktv = 14'h0080;
    t0 = tsm;
    tick();
    out_aktv = '0;
    tick();
    checks++;
    if (obs !== hdr_exp(32'd5, 14'h0080)) begin errors++; $display("FAIL rmid_new_hdr got %h want %h (model ts %0d)", obs, hdr_exp(32'd5, 14'h0080), t0); end
    tick();
    checks++;
    if (obs !== dat_exp(8'd7, 64'd99, 1'b1)) begin errors++; $display("FAIL rmid_new_data got %h", obs); end
    tick();
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL rmid_idle got %h want 0", obs); end
  endtask

  task automatic test_ts_wrap();
    en  = 1'b0;
    en8 = 1'b1;
    repeat (255) tick();
    set_out(0, 64'd5);
    out_aktv = 14'h0001;
    tick();
    set_out(0, 64'd6);
    tick();
    out_aktv = '0;
    checks++;
    if (obs8 !== hdr8_exp(8'd255, 14'h0001)) begin errors++; $display("FAIL wrap_hdr255 got %h want %h (model ts %0d)", obs8, hdr8_exp(8'd255, 14'h0001), tsm8); end
    tick();
    checks++;
    if (obs8 !== dat_exp(8'd0, 64'd5, 1'b1)) begin errors++; $display("FAIL wrap_data5 got %h", obs8); end
    tick();
    checks++;
    if (obs8 !== hdr8_exp(8'd0, 14'h0001)) begin errors++; $display("FAIL wrap_hdr0 got %h want %h", obs8, hdr8_exp(8'd0, 14'h0001)); end
    tick();
    checks++;
    if (obs8 !== dat_exp(8'd0, 64'd6, 1'b1)) begin errors++; $display("FAIL wrap_data6 got %h", obs8); end
    tick();
    checks++;
    if (obs8 !== 75'd0) begin errors++; $display("FAIL wrap_idle got %h want 0", obs8); end
    checks++;
    if (obs !== 75'd0) begin errors++; $display("FAIL wrap_main_quiet got %h want 0", obs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_ts_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
